// File: rtl/sweep_cmd_pkg.sv
// Shared constants for the sweep/SCurve command decoder: command addresses,
// FSM state encoding and echo status word layout.
`timescale 1ns/1ps
package sweep_cmd_pkg;

  localparam logic [7:0] ADDR_MODE     = 8'h10;
  localparam logic [7:0] ADDR_CHMASK   = 8'h11;
  localparam logic [7:0] ADDR_DISCRI   = 8'h12;
  localparam logic [7:0] ADDR_CTEST    = 8'h13;
  localparam logic [7:0] ADDR_SINGLE   = 8'h14;
  localparam logic [7:0] ADDR_FLAGS    = 8'h15;
  localparam logic [7:0] ADDR_SCLOAD   = 8'h20;
  localparam logic [7:0] ADDR_RUN      = 8'h21;
  localparam logic [7:0] ADDR_DAC0     = 8'h80;
  localparam logic [7:0] ADDR_DAC1     = 8'h81;
  localparam logic [7:0] ADDR_DAC2     = 8'h82;
  localparam logic [7:0] ADDR_STARTDAC = 8'h83;
  localparam logic [7:0] ADDR_ENDDAC   = 8'h84;
  localparam logic [7:0] ADDR_MAXPKG   = 8'h85;
  localparam logic [7:0] ADDR_CPTMAX   = 8'h86;
  localparam logic [7:0] ADDR_CNTMAX   = 8'h87;

  localparam int unsigned CMD_W         = 16;
  localparam int unsigned ECHO_OK_BIT   = 14;
  localparam int unsigned ECHO_ADDR_LSB = 0;
  localparam int unsigned ECHO_ADDR_W   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    PWAIT = 3'd2,
    PAY   = 3'd3,
    EXEC  = 3'd4
  } cmdStateT;

  // Status word {1'b0, ok, 6'b0, addr}
  function automatic logic [CMD_W-1:0] echoWord(input logic ok, input logic [7:0] addr);
    logic [CMD_W-1:0] w;
    w = '0;
    w[ECHO_OK_BIT] = ok;
    w[ECHO_ADDR_LSB +: ECHO_ADDR_W] = addr;
    return w;
  endfunction

endpackage

// File: rtl/sweep_cmd_decoder_if.sv
// Command FIFO read port and echo status port between the USB FIFOs and the decoder.
`timescale 1ns/1ps
interface sweep_cmd_decoder_if;
  logic        CmdFifoEmpty;
  logic [15:0] CmdFifoData;
  logic        CmdFifoRdEn;
  logic [15:0] EchoData;
  logic        EchoData_en;

  modport master (
    output CmdFifoEmpty, CmdFifoData,
    input  CmdFifoRdEn, EchoData, EchoData_en
  );

  modport slave (
    input  CmdFifoEmpty, CmdFifoData,
    output CmdFifoRdEn, EchoData, EchoData_en
  );
endinterface

// File: rtl/sweep_cmd_decoder.sv
// Decodes host command words into sweep/SCurve parameters and start strobes.
// Optional CMD_ECHO_EN: emit one status word per command (and per payload timeout).
`timescale 1ns/1ps
module sweep_cmd_decoder
  import sweep_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter logic [15:0] CPT_MAX_RST     = 16'd100,
  parameter logic [15:0] COUNTER_MAX_RST = 16'd5000
) (
  input  logic                Clk,
  input  logic                reset_n,
  sweep_cmd_decoder_if.slave  cmdBus,
  input  logic                SweepTestDone,
  output logic [1:0]          ModeSelect,
  output logic [9:0]          Dac0,
  output logic [9:0]          Dac1,
  output logic [9:0]          Dac2,
  output logic [6:0]          ChannelMask,
  output logic [1:0]          DiscriMask,
  output logic [6:0]          CTestChannel,
  output logic                ScOrReadreg,
  output logic                ScParamLoad,
  output logic                SweepStart,
  output logic [9:0]          StartDac,
  output logic [9:0]          EndDac,
  output logic [15:0]         MaxPackageNumber,
  output logic [15:0]         CptMax,
  output logic [15:0]         CounterMax,
  output logic                TrigEffiOrCountEffi,
  output logic                SingleOr64Chn,
  output logic                CTestOrInput,
  output logic [5:0]          SingleTestChannel,
  output logic [7:0]          ErrorCount
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  cmdStateT         state, nextState;
  logic [7:0]       hdrAddr;
  logic [7:0]       cmdAddr;
  logic [TMO_W-1:0] tmoCnt;
  logic             rdEn_c;
  logic             execStb;
  logic             tmoHit;
  logic             execOk;
  logic             running;

  assign cmdBus.CmdFifoRdEn = rdEn_c;
  // A done pulse in the execute cycle frees the run before the command is judged
  assign running = SweepStart & ~SweepTestDone;
  assign cmdAddr = (state == HDR) ? cmdBus.CmdFifoData[15:8] : hdrAddr;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    rdEn_c    = 1'b0;
    execStb   = 1'b0;
    tmoHit    = 1'b0;
    case (state)
      IDLE: begin
        if (!cmdBus.CmdFifoEmpty) begin
          rdEn_c    = 1'b1;
          nextState = HDR;
        end
      end
      HDR: begin
        if (cmdBus.CmdFifoData[15]) begin
          nextState = PWAIT;
        end else begin
          execStb   = 1'b1;
          nextState = EXEC;
        end
      end
      PWAIT: begin
        if (!cmdBus.CmdFifoEmpty) begin
          rdEn_c    = 1'b1;
          nextState = PAY;
        end else if (tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmoHit    = 1'b1;
          nextState = IDLE;
        end
      end
      PAY: begin
        execStb   = 1'b1;
        nextState = EXEC;
      end
      EXEC:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Accept/reject decision for the word currently on CmdFifoData
  always_comb begin
    execOk = 1'b0;
    case (cmdAddr)
      ADDR_MODE, ADDR_CHMASK, ADDR_DISCRI, ADDR_CTEST, ADDR_SINGLE, ADDR_FLAGS,
      ADDR_MAXPKG, ADDR_CPTMAX, ADDR_CNTMAX:
        execOk = 1'b1;
      ADDR_SCLOAD, ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_STARTDAC, ADDR_ENDDAC:
        execOk = ~running;
      ADDR_RUN:
        execOk = cmdBus.CmdFifoData[0] ? (~running && (StartDac <= EndDac)) : 1'b1;
      default:
        execOk = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      hdrAddr             <= '0;
      tmoCnt              <= '0;
      ModeSelect          <= '0;
      Dac0                <= '0;
      Dac1                <= '0;
      Dac2                <= '0;
      ChannelMask         <= '0;
      DiscriMask          <= '0;
      CTestChannel        <= '0;
      ScOrReadreg         <= 1'b0;
      ScParamLoad         <= 1'b0;
      SweepStart          <= 1'b0;
      StartDac            <= '0;
      EndDac              <= '0;
      MaxPackageNumber    <= '0;
      CptMax              <= CPT_MAX_RST;
      CounterMax          <= COUNTER_MAX_RST;
      TrigEffiOrCountEffi <= 1'b0;
      SingleOr64Chn       <= 1'b0;
      CTestOrInput        <= 1'b0;
      SingleTestChannel   <= '0;
      ErrorCount          <= '0;
    end else begin
      ScParamLoad <= 1'b0;
      SweepStart  <= SweepStart & ~SweepTestDone;

      if (state == HDR) begin
        hdrAddr <= cmdBus.CmdFifoData[15:8];
        tmoCnt  <= '0;
      end else if (state == PWAIT && cmdBus.CmdFifoEmpty) begin
        tmoCnt <= tmoCnt + TMO_W'(1);
      end

      if (((execStb && !execOk) || tmoHit) && ErrorCount != 8'hFF)
        ErrorCount <= ErrorCount + 8'd1;

      if (execStb && execOk) begin
        case (cmdAddr)
          ADDR_MODE:     ModeSelect        <= cmdBus.CmdFifoData[1:0];
          ADDR_CHMASK:   ChannelMask       <= cmdBus.CmdFifoData[6:0];
          ADDR_DISCRI:   DiscriMask        <= cmdBus.CmdFifoData[1:0];
          ADDR_CTEST:    CTestChannel      <= cmdBus.CmdFifoData[6:0];
          ADDR_SINGLE:   SingleTestChannel <= cmdBus.CmdFifoData[5:0];
          ADDR_FLAGS: begin
            TrigEffiOrCountEffi <= cmdBus.CmdFifoData[0];
            SingleOr64Chn       <= cmdBus.CmdFifoData[1];
            CTestOrInput        <= cmdBus.CmdFifoData[2];
            ScOrReadreg         <= cmdBus.CmdFifoData[3];
          end
          ADDR_SCLOAD:   ScParamLoad      <= 1'b1;
          ADDR_RUN:      SweepStart       <= cmdBus.CmdFifoData[0];
          ADDR_DAC0:     Dac0             <= cmdBus.CmdFifoData[9:0];
          ADDR_DAC1:     Dac1             <= cmdBus.CmdFifoData[9:0];
          ADDR_DAC2:     Dac2             <= cmdBus.CmdFifoData[9:0];
          ADDR_STARTDAC: StartDac         <= cmdBus.CmdFifoData[9:0];
          ADDR_ENDDAC:   EndDac           <= cmdBus.CmdFifoData[9:0];
          ADDR_MAXPKG:   MaxPackageNumber <= cmdBus.CmdFifoData;
          ADDR_CPTMAX:   CptMax           <= cmdBus.CmdFifoData;
          ADDR_CNTMAX:   CounterMax       <= cmdBus.CmdFifoData;
          default: ;
        endcase
      end
    end
  end

`ifdef CMD_ECHO_EN
  logic [15:0] echoData;
  logic        echoEn;

  // Status word lands in the EXEC cycle (or the IDLE cycle after a timeout)
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      echoData <= '0;
      echoEn   <= 1'b0;
    end else begin
      echoEn <= execStb | tmoHit;
      if (execStb || tmoHit) echoData <= echoWord(execStb & execOk, cmdAddr);
    end
  end

  assign cmdBus.EchoData    = echoData;
  assign cmdBus.EchoData_en = echoEn;
`else
  assign cmdBus.EchoData    = '0;
  assign cmdBus.EchoData_en = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_cmd_decoder.sv
// Self-checking bench for sweep_cmd_decoder: directed table, corner sequences and
// randomized commands against a command-level reference model.
`timescale 1ns/1ps
module tb_sweep_cmd_decoder;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SweepTestDone = 1'b0;
  logic [1:0]  ModeSelect;
  logic [9:0]  Dac0, Dac1, Dac2;
  logic [6:0]  ChannelMask;
  logic [1:0]  DiscriMask;
  logic [6:0]  CTestChannel;
  logic        ScOrReadreg, ScParamLoad, SweepStart;
  logic [9:0]  StartDac, EndDac;
  logic [15:0] MaxPackageNumber, CptMax, CounterMax;
  logic        TrigEffiOrCountEffi, SingleOr64Chn, CTestOrInput;
  logic [5:0]  SingleTestChannel;
  logic [7:0]  ErrorCount;

  sweep_cmd_decoder_if bus();

  sweep_cmd_decoder dut (
    .Clk(Clk), .reset_n(reset_n), .cmdBus(bus), .SweepTestDone(SweepTestDone),
    .ModeSelect(ModeSelect), .Dac0(Dac0), .Dac1(Dac1), .Dac2(Dac2),
    .ChannelMask(ChannelMask), .DiscriMask(DiscriMask), .CTestChannel(CTestChannel),
    .ScOrReadreg(ScOrReadreg), .ScParamLoad(ScParamLoad), .SweepStart(SweepStart),
    .StartDac(StartDac), .EndDac(EndDac), .MaxPackageNumber(MaxPackageNumber),
    .CptMax(CptMax), .CounterMax(CounterMax), .TrigEffiOrCountEffi(TrigEffiOrCountEffi),
    .SingleOr64Chn(SingleOr64Chn), .CTestOrInput(CTestOrInput),
    .SingleTestChannel(SingleTestChannel), .ErrorCount(ErrorCount)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Command FIFO model: main process pushes, this block pops
  logic [15:0] fifoMem [0:4095];
  int pushCnt = 0;
  int popCnt = 0;
  int rdEmptyErr = 0;
  assign bus.CmdFifoEmpty = (pushCnt == popCnt);

  always @(posedge Clk) begin
    if (bus.CmdFifoRdEn === 1'b1) begin
      if (pushCnt == popCnt) rdEmptyErr <= rdEmptyErr + 1;
      else begin
        bus.CmdFifoData <= fifoMem[popCnt % 4096];
        popCnt <= popCnt + 1;
      end
    end
  end

  int echoCnt = 0;
  logic [15:0] lastEcho = 16'h0;
  always @(posedge Clk) begin
    if (bus.EchoData_en === 1'b1) begin
      echoCnt  <= echoCnt + 1;
      lastEcho <= bus.EchoData;
    end
  end

  typedef struct packed {
    logic [1:0]  mode;
    logic [9:0]  dac0, dac1, dac2;
    logic [6:0]  chMask;
    logic [1:0]  discri;
    logic [6:0]  cTest;
    logic        scOr, scLoad, sweep;
    logic [9:0]  startDac, endDac;
    logic [15:0] maxPkg, cptMax, cntMax;
    logic        trig, single, ctestIn;
    logic [5:0]  singleCh;
    logic [7:0]  err;
  } outT;

  outT mdl;
  logic [15:0] mdlEcho;

  function automatic outT dutOut();
    outT o;
    o.mode = ModeSelect; o.dac0 = Dac0; o.dac1 = Dac1; o.dac2 = Dac2;
    o.chMask = ChannelMask; o.discri = DiscriMask; o.cTest = CTestChannel;
    o.scOr = ScOrReadreg; o.scLoad = ScParamLoad; o.sweep = SweepStart;
    o.startDac = StartDac; o.endDac = EndDac; o.maxPkg = MaxPackageNumber;
    o.cptMax = CptMax; o.cntMax = CounterMax; o.trig = TrigEffiOrCountEffi;
    o.single = SingleOr64Chn; o.ctestIn = CTestOrInput; o.singleCh = SingleTestChannel;
    o.err = ErrorCount;
    return o;
  endfunction

  task automatic modelReset();
    mdl = '0;
    mdl.cptMax = 16'd100;
    mdl.cntMax = 16'd5000;
  endtask

  // Command-level reference: effect of one complete command on the visible registers
  task automatic modelCmd(input logic [15:0] hdr, input logic [15:0] pay);
    logic [7:0]  addr;
    logic [15:0] d;
    logic        ok;
    logic        dacWrite;
    addr = hdr[15:8];
    d = hdr[15] ? pay : {8'h00, hdr[7:0]};
    ok = 1'b1;
    dacWrite = (addr >= 8'h80 && addr <= 8'h84);
    if ((dacWrite || addr == 8'h20) && mdl.sweep) ok = 1'b0;
    else case (addr)
      8'h10: mdl.mode = d[1:0];
      8'h11: mdl.chMask = d[6:0];
      8'h12: mdl.discri = d[1:0];
      8'h13: mdl.cTest = d[6:0];
      8'h14: mdl.singleCh = d[5:0];
      8'h15: {mdl.scOr, mdl.ctestIn, mdl.single, mdl.trig} = d[3:0];
      8'h20: ;
      8'h21: begin
        if (!d[0]) mdl.sweep = 1'b0;
        else if (mdl.sweep || mdl.startDac > mdl.endDac) ok = 1'b0;
        else mdl.sweep = 1'b1;
      end
      8'h80: mdl.dac0 = d[9:0];
      8'h81: mdl.dac1 = d[9:0];
      8'h82: mdl.dac2 = d[9:0];
      8'h83: mdl.startDac = d[9:0];
      8'h84: mdl.endDac = d[9:0];
      8'h85: mdl.maxPkg = d;
      8'h86: mdl.cptMax = d;
      8'h87: mdl.cntMax = d;
      default: ok = 1'b0;
    endcase
    if (!ok && mdl.err != 8'd255) mdl.err = mdl.err + 8'd1;
    mdlEcho = {1'b0, ok, 6'b0, addr};
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushWord(input logic [15:0] w);
    fifoMem[pushCnt % 4096] = w;
    pushCnt = pushCnt + 1;
  endtask

  task automatic sendCmd(input logic [15:0] hdr, input logic [15:0] pay, input int gap);
    @(negedge Clk);
    pushWord(hdr);
    if (hdr[15]) begin
      repeat (gap) @(negedge Clk);
      pushWord(pay);
    end
    repeat (8) @(negedge Clk);
  endtask

  // Push one word and return at the cycle its read strobe is seen (bounded)
  task automatic pushAndFindRdEn(input logic [15:0] w, input string name);
    bit found;
    @(negedge Clk);
    pushWord(w);
    #1;
    found = (bus.CmdFifoRdEn === 1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      #1;
      found = (bus.CmdFifoRdEn === 1'b1);
    end
    check({name, "_rden_seen"}, 160'(found), 160'(1'b1));
  endtask

  function automatic logic [15:0] getSel(input int sel);
    case (sel)
      0: return 16'(ModeSelect);
      1: return 16'(Dac0);
      2: return 16'(StartDac);
      3: return 16'(EndDac);
      4: return 16'(SweepStart);
      5: return 16'(ErrorCount);
      6: return CptMax;
      7: return CounterMax;
      8: return MaxPackageNumber;
      9: return 16'(ChannelMask);
      default: return 16'({ScOrReadreg, CTestOrInput, SingleOr64Chn, TrigEffiOrCountEffi});
    endcase
  endfunction

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] pay;
    int          sel;
    logic [15:0] exp;
    logic [7:0]  expErr;
  } vecT;

  vecT vecs [20];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hdr, pay;
    logic [7:0]  addr;
    int          r, prevEcho;

    vecs[0]  = '{16'h1003, 16'h0000, 0, 16'h0003, 8'd0};
    vecs[1]  = '{16'h8000, 16'h03FF, 1, 16'h03FF, 8'd0};
    vecs[2]  = '{16'h8300, 16'h0010, 2, 16'h0010, 8'd0};
    vecs[3]  = '{16'h8400, 16'h0200, 3, 16'h0200, 8'd0};
    vecs[4]  = '{16'h2101, 16'h0000, 4, 16'h0001, 8'd0};
    vecs[5]  = '{16'h8000, 16'h0001, 1, 16'h03FF, 8'd1};
    vecs[6]  = '{16'h2101, 16'h0000, 4, 16'h0001, 8'd2};
    vecs[7]  = '{16'h2000, 16'h0000, 5, 16'h0003, 8'd3};
    vecs[8]  = '{16'h2100, 16'h0000, 4, 16'h0000, 8'd3};
    vecs[9]  = '{16'h8300, 16'h0200, 2, 16'h0200, 8'd3};
    vecs[10] = '{16'h8400, 16'h0010, 3, 16'h0010, 8'd3};
    vecs[11] = '{16'h2101, 16'h0000, 4, 16'h0000, 8'd4};
    vecs[12] = '{16'h3F00, 16'h0000, 5, 16'h0005, 8'd5};
    vecs[13] = '{16'h8612, 16'h1234, 6, 16'h1234, 8'd5};
    vecs[14] = '{16'h8700, 16'hBEEF, 7, 16'hBEEF, 8'd5};
    vecs[15] = '{16'h8500, 16'h00FF, 8, 16'h00FF, 8'd5};
    vecs[16] = '{16'h1155, 16'h0000, 9, 16'h0055, 8'd5};
    vecs[17] = '{16'h150F, 16'h0000, 10, 16'h000F, 8'd5};
    vecs[18] = '{16'h1A00, 16'h0000, 5, 16'h0006, 8'd6};
    vecs[19] = '{16'h9000, 16'h1111, 5, 16'h0007, 8'd7};

    repeat (3) @(negedge Clk);
    modelReset();
    check("reset_state", 160'(dutOut()), 160'(mdl));
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 20; i++) begin
      sendCmd(vecs[i].hdr, vecs[i].pay, i % 3);
      check($sformatf("vec%0d_value", i), 160'(getSel(vecs[i].sel)), 160'(vecs[i].exp));
      check($sformatf("vec%0d_err", i), 160'(ErrorCount), 160'(vecs[i].expErr));
    end

    // Short command latency: output updates two cycles after the read strobe
    pushAndFindRdEn(16'h1001, "latency");
    @(negedge Clk);
    check("latency_t1_old", 160'(ModeSelect), 160'(2'd3));
    @(negedge Clk);
    check("latency_t2_new", 160'(ModeSelect), 160'(2'd1));
    repeat (4) @(negedge Clk);

    // SC load pulse width and echo word
    pushAndFindRdEn(16'h2000, "scload");
    @(negedge Clk);
    check("scload_t1", 160'(ScParamLoad), 160'(1'b0));
    @(negedge Clk);
    check("scload_t2", 160'(ScParamLoad), 160'(1'b1));
`ifdef CMD_ECHO_EN
    check("echo_scload", 160'({bus.EchoData_en, bus.EchoData}), 160'({1'b1, 16'h4020}));
`else
    check("echo_off", 160'({bus.EchoData_en, bus.EchoData}), 160'(17'h0));
`endif
    @(negedge Clk);
    check("scload_t3", 160'({ScParamLoad, bus.EchoData_en}), 160'(2'b00));
    repeat (4) @(negedge Clk);

    // Run control: done clears; done coinciding with a start lets the start through
    sendCmd(16'h8300, 16'h0010, 0);
    sendCmd(16'h8400, 16'h0200, 0);
    sendCmd(16'h2101, 16'h0000, 0);
    check("run_start", 160'(SweepStart), 160'(1'b1));
    SweepTestDone = 1'b1;
    @(negedge Clk);
    SweepTestDone = 1'b0;
    check("done_clears", 160'(SweepStart), 160'(1'b0));
    sendCmd(16'h2101, 16'h0000, 0);
    pushAndFindRdEn(16'h2101, "done_start");
    @(negedge Clk);
    SweepTestDone = 1'b1;
    @(negedge Clk);
    SweepTestDone = 1'b0;
    check("done_start_same", 160'({SweepStart, ErrorCount}), 160'({1'b1, 8'd7}));
    repeat (4) @(negedge Clk);
    sendCmd(16'h2100, 16'h0000, 0);
    check("stop", 160'(SweepStart), 160'(1'b0));

    // Payload timeout, then a payload that arrives just before the limit
    @(negedge Clk);
    pushWord(16'h8600);
    repeat (1100) @(negedge Clk);
    check("timeout_err", 160'({ErrorCount, CptMax}), 160'({8'd8, 16'h1234}));
`ifdef CMD_ECHO_EN
    check("timeout_echo", 160'(lastEcho), 160'(16'h0086));
`endif
    sendCmd(16'h1002, 16'h0000, 0);
    check("after_timeout", 160'({ModeSelect, ErrorCount}), 160'({2'd2, 8'd8}));
    sendCmd(16'h8600, 16'h0042, 1000);
    check("late_payload", 160'({CptMax, ErrorCount}), 160'({16'h0042, 8'd8}));

    // Reset in the middle of a long command
    @(negedge Clk);
    pushWord(16'h8000);
    repeat (4) @(negedge Clk);
    reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    modelReset();
    check("reset_mid", 160'(dutOut()), 160'(mdl));
    reset_n = 1'b1;
    sendCmd(16'h1001, 16'h0000, 0);
    modelCmd(16'h1001, 16'h0000);
    check("after_reset", 160'(dutOut()), 160'(mdl));

    // Randomized commands against the reference model
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge Clk);
        SweepTestDone = 1'b1;
        @(negedge Clk);
        SweepTestDone = 1'b0;
        mdl.sweep = 1'b0;
      end
      r = int'($urandom_range(0, 18));
      if (r < 6)       addr = 8'h10 + 8'(r);
      else if (r == 6) addr = 8'h20;
      else if (r < 9)  addr = 8'h21;
      else if (r < 17) addr = 8'h80 + 8'(r - 9);
      else if (r == 17) addr = 8'h30 + 8'($urandom_range(0, 15));
      else             addr = 8'h90 + 8'($urandom_range(0, 15));
      hdr = {addr, 8'($urandom)};
      pay = 16'($urandom);
      prevEcho = echoCnt;
      sendCmd(hdr, pay, int'($urandom_range(0, 4)));
      modelCmd(hdr, pay);
      check($sformatf("rand%0d_%04h_%04h", it, hdr, pay), 160'(dutOut()), 160'(mdl));
`ifdef CMD_ECHO_EN
      check($sformatf("rand%0d_echo", it), 160'({32'(echoCnt - prevEcho), lastEcho}),
            160'({32'd1, mdlEcho}));
`endif
    end

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      sendCmd(16'h3000, 16'h0000, 0);
      modelCmd(16'h3000, 16'h0000);
    end
    check("err_saturate", 160'(dutOut()), 160'(mdl));
    check("err_at_255", 160'(ErrorCount), 160'(8'd255));

    check("rden_when_empty", 160'(rdEmptyErr), 160'(0));
    check("fifo_drained", 160'(popCnt), 160'(pushCnt));
`ifndef CMD_ECHO_EN
    check("echo_quiet", 160'(echoCnt), 160'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
